// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC scan scheduler.
// Holds the FSM state encoding, the datapath widths and the lowest-channel picker.
package adc_sched_pkg;

    localparam int ADC_DATA_W          = 12;
    localparam int CH_W                = 3;
    localparam int NUM_CH              = 8;
    localparam int DEFAULT_TIMEOUT_CYC = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_CONVERT,
        ST_CAPTURE,
        ST_NEXT
    } state_t;

    // Scanning downward leaves the lowest set bit as the final assignment.
    function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] mask);
        lowest_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) lowest_ch = CH_W'(i);
        end
    endfunction

endpackage

// File: rtl/adc_fim_sync.sv
// Brings the asynchronous end-of-sample pulse into the clock domain
// and turns its rising edge into a single-cycle strobe.
module adc_fim_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic fim,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(fim);
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/adc_scan_scheduler.sv
// Periodically scans the enabled ADC channels, one conversion at a time,
// and hands each result to a valid/ready consumer with sticky error flags.
module adc_scan_scheduler
    import adc_sched_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iEN,
    input  logic [NUM_CH-1:0]     iCH_MASK,
    input  logic [15:0]           iPERIOD,
    input  logic                  iCLR,
    output logic                  oGO,
    output logic [CH_W-1:0]       oCH,
    input  logic                  iFIM,
    input  logic [ADC_DATA_W-1:0] iADC_DATA,
    output logic [ADC_DATA_W-1:0] oDATA,
    output logic [CH_W-1:0]       oDATA_CH,
    output logic                  oVALID,
    input  logic                  iREADY,
    output logic                  oBUSY,
    output logic                  oOVERRUN,
    output logic                  oTIMEOUT
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state_q;
    logic [15:0]       timer_q;
    logic [15:0]       period_m1;
    logic              tick;
    logic [NUM_CH-1:0] scan_mask_q;
    logic [NUM_CH-1:0] visited_q;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] pick_src;
    logic [CH_W-1:0]   pick_ch;
    logic [TMO_W-1:0]  tmo_q;
    logic              next_wait_q;
    logic              go_q;
    logic [CH_W-1:0]   ch_q;
    logic              fim_rise;
    logic              tmo_evt;
    logic              capture;
    logic              drop;
    logic              tick_busy;

    adc_fim_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_fim_sync (
        .clk (iCLK),
        .rst (iRST),
        .fim (iFIM),
        .rise(fim_rise)
    );

    // A zero period behaves like a period of one: a tick every cycle.
    assign period_m1 = (iPERIOD == 16'd0) ? 16'd0 : (iPERIOD - 16'd1);
    assign tick      = iEN && (timer_q >= period_m1);

    always_ff @(posedge iCLK) begin
        if (iRST || !iEN || tick) begin
            timer_q <= 16'd0;
        end else begin
            timer_q <= timer_q + 16'd1;
        end
    end

    // The channel is chosen on entry to SELECT so oCH settles a full cycle before oGO.
    assign pending  = scan_mask_q & ~visited_q;
    assign pick_src = (state_q == ST_IDLE) ? iCH_MASK : pending;
    assign pick_ch  = lowest_ch(pick_src);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            scan_mask_q <= '0;
            visited_q   <= '0;
            tmo_q       <= '0;
            next_wait_q <= 1'b0;
            go_q        <= 1'b0;
            ch_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick && (iCH_MASK != '0)) begin
                        scan_mask_q <= iCH_MASK;
                        visited_q   <= NUM_CH'(1) << pick_ch;
                        ch_q        <= pick_ch;
                        state_q     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    go_q    <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    if (fim_rise) begin
                        go_q    <= 1'b0;
                        state_q <= ST_CAPTURE;
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        go_q        <= 1'b0;
                        next_wait_q <= 1'b0;
                        state_q     <= ST_NEXT;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    next_wait_q <= 1'b0;
                    state_q     <= ST_NEXT;
                end
                ST_NEXT: begin
                    // Two cycles here give the ADC controller time to rearm.
                    if (!next_wait_q) begin
                        next_wait_q <= 1'b1;
                    end else if (iEN && (pending != '0)) begin
                        visited_q <= visited_q | (NUM_CH'(1) << pick_ch);
                        ch_q      <= pick_ch;
                        state_q   <= ST_SELECT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    go_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign capture   = (state_q == ST_CAPTURE);
    assign drop      = capture && oVALID && !iREADY;
    assign tick_busy = tick && (state_q != ST_IDLE);
    assign tmo_evt   = (state_q == ST_CONVERT) && !fim_rise &&
                       (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Set events take priority over a simultaneous clear of the sticky flags.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDATA    <= '0;
            oDATA_CH <= '0;
            oVALID   <= 1'b0;
            oOVERRUN <= 1'b0;
            oTIMEOUT <= 1'b0;
        end else begin
            if (capture && (!oVALID || iREADY)) begin
                oDATA    <= iADC_DATA;
                oDATA_CH <= ch_q;
                oVALID   <= 1'b1;
            end else if (oVALID && iREADY) begin
                oVALID <= 1'b0;
            end

            if (drop || tick_busy) begin
                oOVERRUN <= 1'b1;
            end else if (iCLR) begin
                oOVERRUN <= 1'b0;
            end

            if (tmo_evt) begin
                oTIMEOUT <= 1'b1;
            end else if (iCLR) begin
                oTIMEOUT <= 1'b0;
            end
        end
    end

    assign oGO   = go_q;
    assign oCH   = ch_q;
    assign oBUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler: an ADC model answers conversion requests
// and a scoreboard matches every accepted sample against queued expectations.
module tb_adc_scan_scheduler;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] data;
    } exp_t;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iEN = 1'b0;
    logic [7:0]  iCH_MASK = 8'h00;
    logic [15:0] iPERIOD = 16'd0;
    logic        iCLR = 1'b0;
    logic        oGO;
    logic [2:0]  oCH;
    logic        iFIM = 1'b0;
    logic [11:0] iADC_DATA = 12'h000;
    logic [11:0] oDATA;
    logic [2:0]  oDATA_CH;
    logic        oVALID;
    logic        iREADY = 1'b0;
    logic        oBUSY;
    logic        oOVERRUN;
    logic        oTIMEOUT;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic model_en = 1'b0;
    int   model_delay = 4;
    logic manual_fim = 1'b0;
    int   m_cnt = 0;
    int   m_hold = 0;
    logic m_fired = 1'b0;
    int   ch4_go_count = 0;

    adc_scan_scheduler dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iEN      (iEN),
        .iCH_MASK (iCH_MASK),
        .iPERIOD  (iPERIOD),
        .iCLR     (iCLR),
        .oGO      (oGO),
        .oCH      (oCH),
        .iFIM     (iFIM),
        .iADC_DATA(iADC_DATA),
        .oDATA    (oDATA),
        .oDATA_CH (oDATA_CH),
        .oVALID   (oVALID),
        .iREADY   (iREADY),
        .oBUSY    (oBUSY),
        .oOVERRUN (oOVERRUN),
        .oTIMEOUT (oTIMEOUT)
    );

    always #5 iCLK = ~iCLK;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // ADC model: answers each request with 12'hA00|ch after model_delay cycles.
    always @(negedge iCLK) begin
        if (!model_en) begin
            iFIM    = manual_fim;
            m_cnt   = 0;
            m_hold  = 0;
            m_fired = 1'b0;
        end else begin
            if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) iFIM = 1'b0;
            end
            if (!oGO) begin
                m_cnt   = 0;
                m_fired = 1'b0;
            end else if (!m_fired) begin
                m_cnt++;
                if (m_cnt >= model_delay) begin
                    iADC_DATA = 12'hA00 | {9'd0, oCH};
                    iFIM      = 1'b1;
                    m_fired   = 1'b1;
                    m_hold    = 2;
                end
            end
        end
    end

    always @(negedge iCLK) begin
        if (oGO && (oCH == 3'd4)) ch4_go_count++;
    end

    // Scoreboard monitor: every handshake must match the oldest queued expectation.
    always @(negedge iCLK) begin
        if (oVALID && iREADY) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_sample", {17'd0, oDATA_CH, oDATA}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("sample_ch", 32'(oDATA_CH), 32'(e.ch));
                check_output("sample_data", 32'(oDATA), 32'(e.data));
            end
        end
    end

    function automatic logic sample_sig(input int which);
        case (which)
            0:       sample_sig = oGO;
            1:       sample_sig = oBUSY;
            2:       sample_sig = oVALID;
            3:       sample_sig = oGO && (oCH == 3'd3);
            default: sample_sig = 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic level, input int limit,
                            input string name);
        int   n;
        logic cur;
        n   = 0;
        cur = sample_sig(which);
        while ((cur !== level) && (n < limit)) begin
            @(negedge iCLK);
            n++;
            cur = sample_sig(which);
        end
        check_output(name, 32'(cur), 32'(level));
    endtask

    task automatic wait_empty(input int limit, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < limit)) begin
            @(negedge iCLK);
            n++;
        end
        check_output(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_clear();
        iCLR = 1'b1;
        @(negedge iCLK);
        iCLR = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_go"}, 32'(oGO), 32'd0);
        check_output({tag, "_ch"}, 32'(oCH), 32'd0);
        check_output({tag, "_data"}, 32'(oDATA), 32'd0);
        check_output({tag, "_data_ch"}, 32'(oDATA_CH), 32'd0);
        check_output({tag, "_valid"}, 32'(oVALID), 32'd0);
        check_output({tag, "_busy"}, 32'(oBUSY), 32'd0);
        check_output({tag, "_overrun"}, 32'(oOVERRUN), 32'd0);
        check_output({tag, "_timeout"}, 32'(oTIMEOUT), 32'd0);
    endtask

    task automatic push_exp(input logic [2:0] ch);
        exp_t e;
        e.ch   = ch;
        e.data = 12'hA00 | {9'd0, ch};
        exp_q.push_back(e);
    endtask

    initial begin
        int go_cycles;
        int ch4_base;

        // Reset state.
        iRST = 1'b1;
        repeat (3) @(negedge iCLK);
        check_reset_outputs("reset");
        iRST = 1'b0;
        @(negedge iCLK);

        // Two scans of channels 0 and 2 with an always-ready consumer.
        $display("[TB] scan of mask 05");
        model_en    = 1'b1;
        model_delay = 4;
        iCH_MASK    = 8'h05;
        iPERIOD     = 16'd2000;
        iREADY      = 1'b1;
        push_exp(3'd0); push_exp(3'd2);
        push_exp(3'd0); push_exp(3'd2);
        iEN = 1'b1;
        wait_empty(4500, "mask05_samples");
        iEN = 1'b0;
        wait_sig(1, 1'b0, 50, "mask05_idle");
        check_output("mask05_overrun", 32'(oOVERRUN), 32'd0);
        check_output("mask05_timeout", 32'(oTIMEOUT), 32'd0);

        // Conversion that never completes.
        $display("[TB] timeout on silent ADC");
        model_en = 1'b0;
        iCH_MASK = 8'h01;
        iPERIOD  = 16'd20;
        iEN      = 1'b1;
        wait_sig(0, 1'b1, 100, "tmo_go_rise");
        go_cycles = 1;
        while (oGO && (go_cycles < 400)) begin
            @(negedge iCLK);
            if (oGO) go_cycles++;
        end
        iEN = 1'b0;
        check_output("tmo_go_high_cycles", 32'(go_cycles), 32'd256);
        wait_sig(1, 1'b0, 20, "tmo_idle");
        check_output("tmo_flag", 32'(oTIMEOUT), 32'd1);
        check_output("tmo_no_valid", 32'(oVALID), 32'd0);
        apply_clear();
        check_output("tmo_cleared", 32'(oTIMEOUT), 32'd0);
        check_output("tmo_overrun_cleared", 32'(oOVERRUN), 32'd0);

        // Consumer stalled through a full 8-channel scan.
        $display("[TB] stalled consumer, mask FF");
        model_en = 1'b1;
        iCH_MASK = 8'hFF;
        iPERIOD  = 16'd500;
        iREADY   = 1'b0;
        iEN      = 1'b1;
        wait_sig(2, 1'b1, 600, "stall_first_valid");
        check_output("stall_first_data", 32'(oDATA), 32'h0A00);
        check_output("stall_first_ch", 32'(oDATA_CH), 32'd0);
        check_output("stall_no_overrun_yet", 32'(oOVERRUN), 32'd0);
        wait_sig(0, 1'b1, 50, "stall_ch1_go");
        wait_sig(0, 1'b0, 50, "stall_ch1_done");
        @(negedge iCLK);
        check_output("stall_overrun_second", 32'(oOVERRUN), 32'd1);
        check_output("stall_data_held", 32'(oDATA), 32'h0A00);
        wait_sig(1, 1'b0, 300, "stall_scan_end");
        iEN = 1'b0;
        check_output("stall_end_data", 32'(oDATA), 32'h0A00);
        check_output("stall_end_ch", 32'(oDATA_CH), 32'd0);
        check_output("stall_end_valid", 32'(oVALID), 32'd1);
        push_exp(3'd0);
        @(posedge iCLK);
        #2 iREADY = 1'b1;
        wait_empty(10, "stall_drain");
        @(negedge iCLK);
        check_output("stall_valid_dropped", 32'(oVALID), 32'd0);
        apply_clear();
        check_output("stall_overrun_cleared", 32'(oOVERRUN), 32'd0);

        // Period shorter than a scan: extra ticks are ignored.
        $display("[TB] short period, mask FF");
        iPERIOD = 16'd10;
        for (int c = 0; c < 8; c++) push_exp(3'(c));
        iEN = 1'b1;
        wait_sig(1, 1'b1, 30, "short_busy");
        wait_empty(600, "short_samples");
        iEN = 1'b0;
        wait_sig(1, 1'b0, 20, "short_idle");
        check_output("short_overrun", 32'(oOVERRUN), 32'd1);
        repeat (30) @(negedge iCLK);
        apply_clear();
        check_output("short_overrun_cleared", 32'(oOVERRUN), 32'd0);

        // Reset in the middle of a conversion, then a stray end-of-sample.
        $display("[TB] reset mid-conversion");
        model_delay = 30;
        iCH_MASK    = 8'h01;
        iEN         = 1'b1;
        wait_sig(0, 1'b1, 40, "rst_go_rise");
        repeat (5) @(negedge iCLK);
        iRST     = 1'b1;
        iEN      = 1'b0;
        model_en = 1'b0;
        @(negedge iCLK);
        iRST = 1'b0;
        check_reset_outputs("midrst");
        manual_fim = 1'b1;
        repeat (3) @(negedge iCLK);
        manual_fim = 1'b0;
        repeat (10) @(negedge iCLK);
        check_output("midrst_no_capture", 32'(oVALID), 32'd0);
        check_output("midrst_idle", 32'(oBUSY), 32'd0);

        // Enable dropped while channel 3 converts.
        $display("[TB] enable drop during channel 3");
        model_en    = 1'b1;
        model_delay = 4;
        iCH_MASK    = 8'h7F;
        iPERIOD     = 16'd100;
        ch4_base    = ch4_go_count;
        for (int c = 0; c < 4; c++) push_exp(3'(c));
        iEN = 1'b1;
        wait_sig(3, 1'b1, 300, "endrop_ch3_go");
        iEN = 1'b0;
        wait_sig(1, 1'b0, 60, "endrop_idle");
        wait_empty(10, "endrop_samples");
        repeat (20) @(negedge iCLK);
        check_output("endrop_no_ch4", 32'(ch4_go_count - ch4_base), 32'd0);
        check_output("endrop_busy", 32'(oBUSY), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_scan_scheduler.md
ADC_SCAN_SCHEDULER -- requirements
Module: adc_scan_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYC, default 256: maximum iCLK cycles allowed per conversion before abort.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for iFIM.
REQ-003 iCLK  in  1  single system clock; all logic on its rising edge.
REQ-004 iRST  in  1  synchronous, active-high reset.
REQ-005 iEN  in  1  scan enable; low = stop scheduling new scans.
REQ-006 iCH_MASK  in  8  channel enable mask, bit n = channel n.
REQ-007 iPERIOD  in  16  scan period in iCLK cycles.
REQ-008 iCLR  in  1  clears sticky status flags.
REQ-009 oGO  out  1  conversion request level to the serial ADC controller.
REQ-010 oCH  out  3  channel address presented to the ADC controller.
REQ-011 iFIM  in  1  end-of-sample pulse from the ADC controller (asynchronous to iCLK).
REQ-012 iADC_DATA  in  12  conversion result from the ADC controller.
REQ-013 oDATA  out  12  captured sample; oDATA_CH  out  3  its channel.
REQ-014 oVALID  out  1  sample available; iREADY  in  1  consumer accepts.
REQ-015 oBUSY  out  1  high while a scan is in progress.
REQ-016 oOVERRUN  out  1  sticky: sample dropped or period tick missed.
REQ-017 oTIMEOUT  out  1  sticky: a conversion aborted on timeout.

Function
REQ-018 Period timer SHALL count iCLK cycles while iEN=1 and emit a one-cycle tick every max(iPERIOD,1) cycles; timer SHALL hold at zero while iEN=0.
REQ-019 FSM states: IDLE, SELECT, CONVERT, CAPTURE, NEXT.
REQ-020 IDLE->SELECT on tick when iEN=1 and iCH_MASK!=0; mask is latched at this transition for the whole scan.
REQ-021 SELECT SHALL pick the lowest enabled channel not yet visited in this scan, drive oCH, and move to CONVERT next cycle; oCH SHALL be stable at least one cycle before oGO rises.
REQ-022 CONVERT SHALL hold oGO=1 and wait for a rising edge of synchronized iFIM; oGO=0 in every other state.
REQ-023 On iFIM edge: CAPTURE, sampling iADC_DATA one cycle later into the output register with oDATA_CH=oCH.
REQ-024 If TIMEOUT_CYC cycles elapse in CONVERT without an iFIM edge, the FSM SHALL set oTIMEOUT, discard the channel, and go to NEXT.
REQ-025 NEXT SHALL return to SELECT if enabled channels remain, otherwise to IDLE; NEXT SHALL hold oGO low at least 2 cycles so the controller rearms.
REQ-026 Output handshake: oVALID SHALL rise with the captured sample and fall the cycle after oVALID&iREADY; oDATA/oDATA_CH SHALL be stable while oVALID=1 and iREADY=0.
REQ-027 A capture while oVALID=1 and iREADY=0 SHALL drop the new sample, keep the old one, and set oOVERRUN.
REQ-028 A tick arriving while oBUSY=1 SHALL be ignored and SHALL set oOVERRUN.
REQ-029 iEN falling mid-scan SHALL let the current conversion finish, then return to IDLE without visiting remaining channels.
REQ-030 iCLR SHALL clear oOVERRUN and oTIMEOUT; a same-cycle set event SHALL win over iCLR.
REQ-031 Capture and consumer accept in the same cycle SHALL load the new sample with oVALID remaining 1 and SHALL NOT set oOVERRUN.
REQ-032 oBUSY SHALL be 1 in every state except IDLE.

Reset
REQ-033 iRST=1 SHALL force IDLE, timer=0, oGO=0, oCH=0, oDATA=0, oDATA_CH=0, oVALID=0, oBUSY=0, oOVERRUN=0, oTIMEOUT=0, synchronizer flops=0.
REQ-034 iRST mid-conversion SHALL drop oGO on the cycle after reset is sampled; any later iFIM edge SHALL be ignored until the next CONVERT.

Structure
REQ-035 Package adc_sched_pkg SHALL hold the FSM state type, ADC_DATA_W=12, CH_W=3, NUM_CH=8 and default TIMEOUT_CYC.
REQ-036 Sub-module adc_fim_sync SHALL implement the SYNC_STAGES synchronizer plus rising-edge detector for iFIM.

Verification
REQ-037 Mask=8'h05, iPERIOD=2000, iREADY=1, model returns 12'hA00|ch: outputs (0,12'hA00) then (2,12'hA02) per scan; oOVERRUN=0.
REQ-038 Mask=8'h01, model never pulses iFIM: oGO falls after 256 cycles in CONVERT, oTIMEOUT=1, no oVALID; iCLR clears it.
REQ-039 Mask=8'hFF, iREADY=0 throughout: first sample held unchanged on oDATA, oOVERRUN=1 at second capture.
REQ-040 iPERIOD=10 with 8-channel scan longer than 10 cycles: ticks during oBUSY ignored, oOVERRUN=1, scans never overlap.
REQ-041 iRST asserted mid-CONVERT for 1 cycle: all outputs at reset values next cycle; late iFIM produces no capture.
REQ-042 iEN dropped during channel 3 of mask 8'h7F: channel 3 sample delivered, oBUSY=0 afterwards, no channel 4 request.
